mem_requester: RTL and testbench

Initiator-side sequencer for the 8-word × 8-bit memory controller. It accepts read and write burst commands from a host over valid/ready handshakes and drives the controller's `R`/`W` strobes, `adr[2:0]` address and write data with the controller's idle → access → idle timing. For reads, it captures `o[7:0]` and returns it to the host. It sits between host logic and the memory controller, and it is the only agent that drives the controller's request pins.

---
 rtl/mem_requester_pkg.sv | 15 +
 rtl/mem_requester_if.sv | 29 ++
 rtl/mem_requester.sv | 154 +++++++++++++++
 tb/tb_mem_requester.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_requester_pkg.sv
// Shared types and default widths for the memory-controller request sequencer.
package mem_req_pkg;

  localparam int AW_DEFAULT = 3;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WD,
    STROBE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/mem_requester_if.sv
// Host-side command / write-beat / read-beat handshakes of the request sequencer.
interface mem_requester_if #(
  parameter int AW = mem_req_pkg::AW_DEFAULT,
  parameter int DW = mem_req_pkg::DW_DEFAULT
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, rd_last, done
  );
endinterface

// File: rtl/mem_requester.sv
// Burst sequencer driving the 8x8 memory controller's R/W strobes, address and
// write data with its idle -> access -> idle timing; read beats return to the host.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
  mem_requester_if.slave host,
  output logic           R,
  output logic           W,
  output logic [AW-1:0]  adr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata
);

  state_t        state_reg, state_next;
  logic [AW-1:0] adr_reg, adr_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          write_reg, write_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          r_reg, r_next;
  logic          w_reg, w_next;
  logic          rd_valid_reg, rd_valid_next;
  logic          rd_last_reg, rd_last_next;
  logic          done_reg, done_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      adr_reg      <= '0;
      cnt_reg      <= '0;
      write_reg    <= 1'b0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      r_reg        <= 1'b0;
      w_reg        <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      adr_reg      <= adr_next;
      cnt_reg      <= cnt_next;
      write_reg    <= write_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      r_reg        <= r_next;
      w_reg        <= w_next;
      rd_valid_reg <= rd_valid_next;
      rd_last_reg  <= rd_last_next;
      done_reg     <= done_next;
    end
  end

  // Strobes and read-beat flags are produced from next-state so they come
  // straight out of flops, aligned with the state they belong to.
  always_comb begin
    state_next    = state_reg;
    adr_next      = adr_reg;
    cnt_next      = cnt_reg;
    write_next    = write_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    r_next        = 1'b0;
    w_next        = 1'b0;
    rd_valid_next = 1'b0;
    rd_last_next  = 1'b0;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (host.cmd_valid && host.cmd_ready) begin
          adr_next   = host.cmd_addr;
          cnt_next   = host.cmd_len;
          write_next = host.cmd_write;
          if (host.cmd_write) begin
            state_next = WAIT_WD;
          end else begin
            state_next = STROBE;
            r_next     = 1'b1;
          end
        end
      end

      WAIT_WD: begin
        if (host.wr_valid) begin
          wdata_next = host.wr_data;
          state_next = STROBE;
          w_next     = 1'b1;
        end
      end

      STROBE: begin
        state_next = ACCESS;
      end

      ACCESS: begin
        if (!write_reg) begin
          rdata_next    = mem_rdata;
          state_next    = RESP;
          rd_valid_next = 1'b1;
          rd_last_next  = (cnt_reg == '0);
        end else if (cnt_reg != '0) begin
          adr_next   = adr_reg + AW'(1);
          cnt_next   = cnt_reg - AW'(1);
          state_next = WAIT_WD;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      RESP: begin
        rd_valid_next = 1'b1;
        rd_last_next  = rd_last_reg;
        if (host.rd_ready) begin
          rd_valid_next = 1'b0;
          rd_last_next  = 1'b0;
          if (cnt_reg != '0) begin
            adr_next   = adr_reg + AW'(1);
            cnt_next   = cnt_reg - AW'(1);
            state_next = STROBE;
            r_next     = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Held low while RST is asserted so no command is taken during reset.
  assign host.cmd_ready = (state_reg == IDLE) && !RST;
  assign host.wr_ready  = (state_reg == WAIT_WD);
  assign host.rd_data   = rdata_reg;
  assign host.rd_valid  = rd_valid_reg;
  assign host.rd_last   = rd_last_reg;
  assign host.done      = done_reg;

  assign R         = r_reg;
  assign W         = w_reg;
  assign adr       = adr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a behavioural 8x8 controller model and
// a protocol monitor on the strobe pins.
module tb_mem_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       R, W;
  logic [2:0] adr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  always #5 clk = ~clk;

  mem_requester_if #(.AW(3), .DW(8)) hif ();

  mem_requester #(.AW(3), .DW(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .host      (hif),
    .R         (R),
    .W         (W),
    .adr       (adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller model: a strobe puts it in its access state for the next cycle,
  // with o[] showing the addressed word; it has no reset.
  logic [7:0] mem_arr [8] = '{default: 8'h00};
  logic       ctl_busy = 1'b0;
  logic [2:0] ctl_adr  = 3'd0;

  always @(posedge clk) begin
    ctl_busy <= R | W;
    if (R | W) begin
      ctl_adr   <= adr;
      mem_rdata <= mem_arr[adr];
      if (W) mem_arr[adr] <= mem_wdata;
    end
  end

  logic monitor_on  = 1'b0;
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (rst || !monitor_on) begin
      prev_strobe = 1'b0;
    end else begin
      check("proto_rw_exclusive", {31'd0, R & W}, 32'd0);
      check("proto_strobe_gap", {31'd0, (R | W) & prev_strobe}, 32'd0);
      check("proto_cmd_ready_busy",
            {31'd0, hif.cmd_ready & (R | W | hif.rd_valid | hif.wr_ready)}, 32'd0);
      if (ctl_busy) check("proto_adr_hold", {29'd0, adr}, {29'd0, ctl_adr});
      prev_strobe = R | W;
    end
  end

  logic [7:0] shadow [8];

  task automatic wait_cmd_ready();
    int t = 0;
    while (!hif.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", {31'd0, hif.cmd_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [2:0] len,
                          input logic [63:0] data, input int sb, input int sc);
    logic [2:0] ea;
    logic [7:0] d;
    wait_cmd_ready();
    hif.cmd_valid = 1'b1;
    hif.cmd_write = 1'b1;
    hif.cmd_addr  = addr;
    hif.cmd_len   = len;
    @(negedge clk);
    hif.cmd_valid = 1'b0;
    hif.cmd_addr  = 3'($urandom);
    check("wr_cmd_ready_low", {31'd0, hif.cmd_ready}, 32'd0);
    for (int b = 0; b <= int'(len); b++) begin
      ea = addr + 3'(b);
      d  = data[b*8 +: 8];
      if (b == sb) begin
        for (int s = 0; s < sc; s++) begin
          check("wr_starve_no_w", {31'd0, W}, 32'd0);
          check("wr_starve_adr", {29'd0, adr}, {29'd0, ea});
          @(negedge clk);
        end
      end
      check("wr_ready", {31'd0, hif.wr_ready}, 32'd1);
      hif.wr_valid = 1'b1;
      hif.wr_data  = d;
      @(negedge clk);
      hif.wr_valid = 1'b0;
      hif.wr_data  = 8'($urandom);
      check("wr_strobe_w", {31'd0, W}, 32'd1);
      check("wr_strobe_r", {31'd0, R}, 32'd0);
      check("wr_strobe_adr", {29'd0, adr}, {29'd0, ea});
      check("wr_strobe_data", {24'd0, mem_wdata}, {24'd0, d});
      check("wr_ready_low", {31'd0, hif.wr_ready}, 32'd0);
      shadow[ea] = d;
      @(negedge clk);
      check("wr_access_w_low", {31'd0, W}, 32'd0);
      check("wr_access_data", {24'd0, mem_wdata}, {24'd0, d});
      @(negedge clk);
    end
    check("wr_done", {31'd0, hif.done}, 32'd1);
    check("wr_done_cmd_ready", {31'd0, hif.cmd_ready}, 32'd1);
    $display("txn write addr=%0d len=%0d data=%016h stall_beat=%0d stall=%0d",
             addr, len, data, sb, sc);
  endtask

  task automatic do_read(input logic [2:0] addr, input logic [2:0] len,
                         input logic [63:0] exp, input int sb, input int sc);
    logic [2:0] ea;
    logic [7:0] e;
    wait_cmd_ready();
    hif.cmd_valid = 1'b1;
    hif.cmd_write = 1'b0;
    hif.cmd_addr  = addr;
    hif.cmd_len   = len;
    @(negedge clk);
    hif.cmd_valid = 1'b0;
    hif.cmd_len   = 3'($urandom);
    for (int b = 0; b <= int'(len); b++) begin
      ea = addr + 3'(b);
      e  = exp[b*8 +: 8];
      check("rd_strobe_r", {31'd0, R}, 32'd1);
      check("rd_strobe_w", {31'd0, W}, 32'd0);
      check("rd_strobe_adr", {29'd0, adr}, {29'd0, ea});
      check("rd_cmd_ready_low", {31'd0, hif.cmd_ready}, 32'd0);
      check("rd_no_done", {31'd0, hif.done}, 32'd0);
      @(negedge clk);
      check("rd_access_r_low", {31'd0, R}, 32'd0);
      check("rd_access_no_valid", {31'd0, hif.rd_valid}, 32'd0);
      @(negedge clk);
      check("rd_valid", {31'd0, hif.rd_valid}, 32'd1);
      check("rd_data", {24'd0, hif.rd_data}, {24'd0, e});
      check("rd_last", {31'd0, hif.rd_last}, {31'd0, b == int'(len)});
      if (b == sb) begin
        for (int s = 0; s < sc; s++) begin
          @(negedge clk);
          check("rd_bp_valid", {31'd0, hif.rd_valid}, 32'd1);
          check("rd_bp_data", {24'd0, hif.rd_data}, {24'd0, e});
          check("rd_bp_no_r", {31'd0, R}, 32'd0);
        end
      end
      hif.rd_ready = 1'b1;
      @(negedge clk);
      hif.rd_ready = 1'b0;
    end
    check("rd_done", {31'd0, hif.done}, 32'd1);
    check("rd_done_cmd_ready", {31'd0, hif.cmd_ready}, 32'd1);
    check("rd_done_valid_low", {31'd0, hif.rd_valid}, 32'd0);
    $display("txn read  addr=%0d len=%0d exp=%016h stall_beat=%0d stall=%0d",
             addr, len, exp, sb, sc);
  endtask

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [2:0]  len;
    logic [63:0] data;   // beat 0 in the low byte
    logic [2:0]  sb;
    logic [2:0]  sc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  ra, rl;
    logic [63:0] rd;

    vecs[0] = '{wr: 1'b1, addr: 3'd5, len: 3'd0, data: 64'h00000000_000000A5, sb: 3'd0, sc: 3'd0};
    vecs[1] = '{wr: 1'b0, addr: 3'd5, len: 3'd0, data: 64'h00000000_000000A5, sb: 3'd0, sc: 3'd0};
    vecs[2] = '{wr: 1'b1, addr: 3'd6, len: 3'd3, data: 64'h00000000_44332211, sb: 3'd0, sc: 3'd0};
    vecs[3] = '{wr: 1'b0, addr: 3'd6, len: 3'd3, data: 64'h00000000_44332211, sb: 3'd1, sc: 3'd5};
    vecs[4] = '{wr: 1'b1, addr: 3'd3, len: 3'd1, data: 64'h00000000_0000C35A, sb: 3'd0, sc: 3'd4};
    vecs[5] = '{wr: 1'b0, addr: 3'd2, len: 3'd3, data: 64'h00000000_A5C35A00, sb: 3'd0, sc: 3'd0};
    vecs[6] = '{wr: 1'b0, addr: 3'd7, len: 3'd1, data: 64'h00000000_00003322, sb: 3'd0, sc: 3'd0};
    vecs[7] = '{wr: 1'b1, addr: 3'd1, len: 3'd0, data: 64'h00000000_0000007E, sb: 3'd0, sc: 3'd0};
    vecs[8] = '{wr: 1'b0, addr: 3'd0, len: 3'd1, data: 64'h00000000_00007E33, sb: 3'd0, sc: 3'd0};

    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    rst           = 1'b1;
    hif.cmd_valid = 1'b0;
    hif.cmd_write = 1'b0;
    hif.cmd_addr  = 3'd0;
    hif.cmd_len   = 3'd0;
    hif.wr_valid  = 1'b0;
    hif.wr_data   = 8'h00;
    hif.rd_ready  = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_R", {31'd0, R}, 32'd0);
    check("reset_W", {31'd0, W}, 32'd0);
    check("reset_adr", {29'd0, adr}, 32'd0);
    check("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("reset_rd_data", {24'd0, hif.rd_data}, 32'd0);
    check("reset_rd_valid", {31'd0, hif.rd_valid}, 32'd0);
    check("reset_rd_last", {31'd0, hif.rd_last}, 32'd0);
    check("reset_wr_ready", {31'd0, hif.wr_ready}, 32'd0);
    check("reset_done", {31'd0, hif.done}, 32'd0);
    check("reset_cmd_ready_low", {31'd0, hif.cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("release_cmd_ready", {31'd0, hif.cmd_ready}, 32'd1);
    monitor_on = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].len, vecs[i].data, int'(vecs[i].sb), int'(vecs[i].sc));
      else
        do_read(vecs[i].addr, vecs[i].len, vecs[i].data, int'(vecs[i].sb), int'(vecs[i].sc));
    end

    for (int i = 0; i < 6; i++) begin
      ra = 3'($urandom_range(0, 7));
      rl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        rd = {$urandom, $urandom};
        do_write(ra, rl, rd, $urandom_range(0, 7), $urandom_range(0, 3));
      end else begin
        rd = '0;
        for (int b = 0; b <= int'(rl); b++) rd[b*8 +: 8] = shadow[ra + 3'(b)];
        do_read(ra, rl, rd, $urandom_range(0, 7), $urandom_range(0, 3));
      end
    end

    // Reset during the ACCESS cycle of the second read beat.
    wait_cmd_ready();
    hif.cmd_valid = 1'b1;
    hif.cmd_write = 1'b0;
    hif.cmd_addr  = 3'd2;
    hif.cmd_len   = 3'd3;
    hif.rd_ready  = 1'b1;
    @(negedge clk);
    hif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_seq_beat0_data", {24'd0, hif.rd_data}, {24'd0, shadow[2]});
    @(negedge clk);
    check("rst_seq_beat1_r", {31'd0, R}, 32'd1);
    check("rst_seq_beat1_adr", {29'd0, adr}, 32'd3);
    @(negedge clk);
    check("rst_seq_access_r_low", {31'd0, R}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_R", {31'd0, R}, 32'd0);
    check("rst_abort_W", {31'd0, W}, 32'd0);
    check("rst_abort_rd_valid", {31'd0, hif.rd_valid}, 32'd0);
    check("rst_abort_done", {31'd0, hif.done}, 32'd0);
    check("rst_abort_cmd_ready", {31'd0, hif.cmd_ready}, 32'd0);
    rst          = 1'b0;
    hif.rd_ready = 1'b0;
    #1;
    check("rst_release_cmd_ready", {31'd0, hif.cmd_ready}, 32'd1);
    $display("txn reset mid-burst addr=2 len=3 aborted on beat 1");
    rd = {56'd0, shadow[0]};
    do_read(3'd0, 3'd0, rd, 0, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
